// File: rtl/spi_master_drv.sv
// -----------------------------------------------------------------------------
// spi_master_drv
// SPI master that ships one operation to an SPI slave and reads back its result.
// A frame is: chip select low, a SETUP half-period, 20 bits out
// {oper[3:0], argA[7:0], argB[7:0]} MSB-first, GAP_BITS idle SCLK periods,
// 12 bits in {result[7:0], flags[3:0]} MSB-first, a HOLD half-period, and
// chip select high. SCLK idles low. MOSI changes on SCLK falling edges and
// MISO is sampled on SCLK rising edges.
//
// Parameters
//   CLK_DIV   system clocks per SCLK half-period (>= 1)
//   GAP_BITS  idle SCLK periods between upload and readback
//
// Ports
//   i_clk_p   system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_start   request a transaction (honoured only while o_busy = 0)
//   i_oper    operation code
//   i_argA    operand A
//   i_argB    operand B
//   o_busy    transaction in progress
//   o_done    one-clock completion pulse, coincident with o_cs rising
//   o_result  captured result, held until the next completion
//   o_flags   captured flags {BF,NF,OF,SF}
//   o_sclk    SPI clock
//   o_mosi    SPI data out
//   o_cs      chip select, active-low
//   i_miso    SPI data in
// -----------------------------------------------------------------------------
module spi_master_drv #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 2
) (
  input  logic       i_clk_p,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_oper,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs,
  input  logic       i_miso
);

  localparam int N_OUT    = 20;
  localparam int N_IN     = 12;
  localparam int N_TOT    = N_OUT + GAP_BITS + N_IN;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = $clog2(N_TOT);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(N_TOT - 1);
  localparam logic [BIT_W-1:0] OUT_END  = BIT_W'(N_OUT);
  localparam logic [BIT_W-1:0] IN_START = BIT_W'(N_OUT + GAP_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT_OUT, ST_GAP, ST_SHIFT_IN, ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  // Bits still to be sent after the one currently on MOSI; zeros shift in
  // behind them so MOSI falls to 0 for the gap and readback on its own.
  logic [18:0]       tx_q, tx_d;
  logic [11:0]       rx_q, rx_d;

  logic              div_tick, shifting, fall_ev, period_end, last_period;
  logic              rise_ev, start_ok, done_ev;
  logic [BIT_W-1:0]  bit_nxt;

  assign div_tick    = (div_q == DIV_MAX);
  assign shifting    = state_q inside {ST_SHIFT_OUT, ST_GAP, ST_SHIFT_IN};
  assign fall_ev     = shifting && sclk_q && div_tick;
  assign period_end  = shifting && !sclk_q && div_tick;
  assign last_period = (bit_q == BIT_MAX);
  assign bit_nxt     = bit_q + 1'b1;
  // SCLK rises at the end of SETUP and at the end of every period but the last.
  assign rise_ev     = (state_q == ST_SETUP && div_tick) || (period_end && !last_period);
  assign start_ok    = (state_q == ST_IDLE) && i_start;
  assign done_ev     = (state_q == ST_HOLD) && div_tick;

  // State register.
  always_ff @(posedge i_clk_p) begin
    // NOTE: every flop, data registers included, is cleared so an aborted
    // frame leaves no partial capture behind.
    if (i_rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETUP;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        div_d = div_tick ? '0 : div_q + 1'b1;
        if (div_tick) state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT, ST_GAP, ST_SHIFT_IN: begin
        div_d = div_tick ? '0 : div_q + 1'b1;
        if (period_end) begin
          if (last_period) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_nxt;
            if (bit_nxt < OUT_END)       state_d = ST_SHIFT_OUT;
            else if (bit_nxt < IN_START) state_d = ST_GAP;
            else                         state_d = ST_SHIFT_IN;
          end
        end
      end
      ST_HOLD: begin
        div_d = div_tick ? '0 : div_q + 1'b1;
        if (div_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered-output and datapath logic.
  always_comb begin
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    tx_d     = tx_q;
    rx_d     = rx_q;

    if (start_ok) begin
      cs_d   = 1'b0;
      busy_d = 1'b1;
      mosi_d = i_oper[3];
      tx_d   = {i_oper[2:0], i_argA, i_argB};
      rx_d   = '0;
    end

    if (rise_ev) begin
      sclk_d = 1'b1;
      // MISO was set up by the slave on the previous falling edge.
      if (state_d == ST_SHIFT_IN) rx_d = {rx_q[10:0], i_miso};
    end

    if (fall_ev) begin
      sclk_d = 1'b0;
      mosi_d = tx_q[18];
      tx_d   = {tx_q[17:0], 1'b0};
    end

    if (done_ev) begin
      cs_d     = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      mosi_d   = 1'b0;
      result_d = rx_q[11:4];
      flags_d  = rx_q[3:0];
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;
  assign o_sclk   = sclk_q;
  assign o_mosi   = mosi_q;
  assign o_cs     = cs_q;

endmodule

// File: doc/spi_master_drv.md
SPI_MASTER_DRV -- requirements
Module: spi_master_drv

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per SCLK half-period (≥1).
REQ-002 SHALL have parameter GAP_BITS, default 2: idle SCLK periods between argument upload and result readback.
REQ-003 SHALL have ports:
- i_clk_p  in  1  system clock, all logic on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  request a transaction.
- i_oper  in  4  operation code.
- i_argA  in  8  operand A.
- i_argB  in  8  operand B.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-clock completion pulse.
- o_result  out  8  captured result.
- o_flags  out  4  captured flags {BF,NF,OF,SF}.
- o_sclk  out  1  SPI clock, idle low.
- o_mosi  out  1  SPI data out.
- o_cs  out  1  chip select, active-low.
- i_miso  in  1  SPI data in.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 SHALL accept i_start only when o_busy=0, latching i_oper/i_argA/i_argB that clock; i_start while busy SHALL be ignored.
REQ-006 SHALL implement states IDLE -> SETUP -> SHIFT_OUT -> GAP -> SHIFT_IN -> HOLD -> IDLE.
REQ-007 IDLE: o_cs=1, o_sclk=0, o_mosi=0, o_busy=0; accepted start -> SETUP with o_cs=0 and o_busy=1 from the next clock.
REQ-008 SETUP SHALL last CLK_DIV clocks with o_sclk=0 and o_mosi = first outgoing bit.
REQ-009 Each SCLK period SHALL be CLK_DIV clocks high, then CLK_DIV clocks low; o_mosi SHALL change only on the clock that drives o_sclk low.
REQ-010 SHIFT_OUT SHALL send 20 bits MSB-first: i_oper[3:0], i_argA[7:0], i_argB[7:0].
REQ-011 GAP SHALL run GAP_BITS SCLK periods with o_mosi=0.
REQ-012 SHIFT_IN SHALL run 12 SCLK periods, sampling i_miso on the clock o_sclk goes high, MSB-first into {result[7:0], flags[3:0]}.
REQ-013 HOLD SHALL keep o_cs=0, o_sclk=0 for CLK_DIV clocks, then o_cs=1 and o_busy=0.
REQ-014 o_done SHALL pulse for exactly one clock, coincident with o_cs returning to 1.
REQ-015 o_result/o_flags SHALL update only in that same clock and SHALL hold until the next completion.
REQ-016 From o_cs fall to o_cs rise SHALL be CLK_DIV*(2*(32+GAP_BITS)+2) clocks.
REQ-017 i_start asserted in the o_done clock SHALL be accepted, giving back-to-back frames; o_cs SHALL then be high for exactly one clock.
REQ-018 Half-period and bit counters SHALL be sized to hold CLK_DIV-1 and 32+GAP_BITS-1 without wrap.

Reset
REQ-019 While i_rst=1 at a clock edge: state=IDLE, o_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_result=0, o_flags=0, counters=0.
REQ-020 Reset mid-frame SHALL abort it: o_cs=1 the next clock, no o_done, captured data discarded.
REQ-021 i_start asserted together with i_rst SHALL be ignored.

Verification
REQ-022 Basic transaction, CLK_DIV=2, GAP_BITS=2: oper=4'h3, A=8'h0F, B=8'h01; slave model returns 12'h10_0.
- MOSI sequence SHALL be 0011_00001111_00000001.
- o_result=8'h10, o_flags=4'h0.
- o_cs low for 140 clocks; single o_done pulse.
REQ-023 Flag capture: slave returns result 8'hFF, flags 4'b1010 -> o_result=8'hFF, o_flags=4'hA.
REQ-024 Busy and back-to-back:
- i_start pulsed mid-frame with new operands -> frame unaffected, no second frame.
- i_start held through o_done -> second frame begins, o_cs high exactly one clock between frames.
REQ-025 Reset at the 10th SCLK rise -> o_cs=1 next clock; o_done never asserts; o_result keeps its prior value of 0.
REQ-026 CLK_DIV=1: same stimulus as REQ-022 -> identical bit sequence, o_cs low for 70 clocks, each SCLK high and low for 1 clock.
